// File: rtl/z_run_monitor.sv
// -----------------------------------------------------------------------------
// z_run_monitor
//
// Consumer of the single-bit registered Z output of the upstream two-register
// stage. Z is sampled on every rising clock edge. The block does three things:
//   * measures the length of each high run of Z and offers it on a one-entry
//     valid/ready holding register;
//   * detects the serial pattern 1-0-1-1 (overlapping) and pulses `match`;
//   * counts matches since reset in `match_cnt` (wraps).
// The first SETTLE samples after reset are ignored, because the upstream stage
// drives Z high while its pipeline flushes.
//
// Parameters
//   CNT_W   width of the run-length and match counters
//   SETTLE  number of post-reset samples to ignore
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset, clears every register
//   z_in       in   Z from the upstream stage (same clock domain)
//   evt_ready  in   consumer accepts evt_data when high with evt_valid
//   evt_valid  out  evt_data holds an unconsumed run length
//   evt_data   out  length in cycles of the completed high run
//   evt_ovf    out  sticky: a run event was dropped (holding register full)
//   match      out  one-cycle pulse when 1011 completes
//   match_cnt  out  number of matches since reset, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module z_run_monitor #(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z_in,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_data,
    output logic             evt_ovf,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt
);

    // Counter wide enough to hold SETTLE itself (it saturates there).
    localparam int SETTLE_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE);
    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } pat_state_t;

    logic [SETTLE_W-1:0] settle_cnt;
    logic                z_prev;
    logic [CNT_W-1:0]    run_len;
    pat_state_t          state;

    // Run length never wraps: a very long run reports the maximum value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    // Overlapping 1011 detector. Each state names the longest suffix of the
    // sample history that is still a prefix of the pattern, so after a hit the
    // trailing 1 is reused (S1) and a 0 after 101 falls back to "10".
    function automatic pat_state_t pat_next(input pat_state_t s, input logic b);
        pat_state_t n;
        n = IDLE;
        case (s)
            IDLE:    n = b ? S1   : IDLE;
            S1:      n = b ? S1   : S10;
            S10:     n = b ? S101 : IDLE;
            S101:    n = b ? S1   : S10;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    // ---- sample decode (combinational, current edge) ----
    logic             vld_p0;
    logic             evt_p0;
    logic             hit_p0;
    logic             drain_p0;
    logic             load_ok_p0;

    // A sample counts only once the settle window has been consumed.
    assign vld_p0     = (settle_cnt == SETTLE_MAX);
    // Falling edge of Z closes a run; run_len still holds its length here.
    assign evt_p0     = vld_p0 && z_prev && !z_in;
    assign hit_p0     = vld_p0 && (state == S101) && z_in;
    // Holding register: drain first, so a drain and a load can share an edge.
    assign drain_p0   = evt_valid && evt_ready;
    assign load_ok_p0 = !evt_valid || drain_p0;

    // ---- sample stage: settle window, run length, pattern FSM ----
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            z_prev     <= 1'b0;
            run_len    <= '0;
            state      <= IDLE;
            match      <= 1'b0;
            match_cnt  <= '0;
        end else begin
            match <= 1'b0;
            if (!vld_p0) begin
                // Upstream flush samples: only advance the settle counter.
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                z_prev  <= z_in;
                run_len <= z_in ? sat_inc(run_len) : '0;
                state   <= pat_next(state, z_in);
                if (hit_p0) begin
                    match     <= 1'b1;
                    match_cnt <= match_cnt + 1'b1;
                end
            end
        end
    end

    // ---- event stage: one-entry valid/ready holding register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_data  <= '0;
            evt_ovf   <= 1'b0;
        end else begin
            if (evt_p0 && load_ok_p0) begin
                evt_valid <= 1'b1;
                evt_data  <= run_len;
            end else if (drain_p0) begin
                evt_valid <= 1'b0;
            end
            // Full and not draining: the new run is lost, evt_data is kept.
            if (evt_p0 && !load_ok_p0) begin
                evt_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_z_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_z_run_monitor
//
// Scoreboard bench for z_run_monitor. The driver applies one input vector per
// clock, advances a reference model that works on the plain sample history
// (trailing ones = run length, last four samples = pattern), and pushes the
// expected post-edge outputs, tagged with the edge number, into a queue. A
// separate monitor pops entries whose edge has occurred and compares them with
// the DUT outputs on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_z_run_monitor;

    localparam int CNT_W  = 8;
    localparam int SETTLE = 2;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             z_in;
    logic             evt_ready;
    logic             evt_valid;
    logic [CNT_W-1:0] evt_data;
    logic             evt_ovf;
    logic             match;
    logic [CNT_W-1:0] match_cnt;

    z_run_monitor #(.CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .z_in      (z_in),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ovf   (evt_ovf),
        .match     (match),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int               tag;
        bit               v;
        logic [CNT_W-1:0] d;
        bit               chk_d;
        bit               ovf;
        bit               m;
        logic [CNT_W-1:0] mc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // ---------------- reference model ----------------
    int               m_settle = 0;
    bit               hist[$];
    bit               m_v = 0;
    logic [CNT_W-1:0] m_d = '0;
    bit               m_ovf = 0;
    bit               m_match = 0;
    int               m_cnt = 0;
    bit               m_rst = 0;

    function automatic void model(input bit r, input bit zz, input bit rd);
        bit drain;
        bit ev;
        int len;
        int n;
        if (r) begin
            m_settle = 0;
            hist.delete();
            m_v = 0; m_d = '0; m_ovf = 0; m_match = 0; m_cnt = 0; m_rst = 1;
            return;
        end
        m_rst   = 0;
        m_match = 0;
        drain   = m_v && rd;
        ev      = 0;
        len     = 0;
        if (m_settle < SETTLE) begin
            m_settle++;
        end else begin
            n = hist.size();
            if (n > 0 && hist[n-1] == 1'b1 && zz == 1'b0) begin
                ev = 1;
                for (int i = n - 1; i >= 0; i--) begin
                    if (!hist[i]) break;
                    len++;
                end
                if (len > MAXV) len = MAXV;
            end
            hist.push_back(zz);
            if (hist.size() > 400) void'(hist.pop_front());
            n = hist.size();
            if (n >= 4 && hist[n-4] && !hist[n-3] && hist[n-2] && hist[n-1]) begin
                m_match = 1;
                m_cnt   = (m_cnt + 1) % (MAXV + 1);
            end
        end
        if (ev) begin
            if (!m_v || drain) begin
                m_v = 1;
                m_d = CNT_W'(len);
            end else begin
                m_ovf = 1;
            end
        end else if (drain) begin
            m_v = 0;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit zz, input bit rd);
        exp_t e;
        @(negedge clk);
        rst       = r;
        z_in      = zz;
        evt_ready = rd;
        model(r, zz, rd);
        e.tag   = edge_cnt + 1;
        e.v     = m_v;
        e.d     = m_d;
        e.chk_d = m_v || m_rst;
        e.ovf   = m_ovf;
        e.m     = m_match;
        e.mc    = CNT_W'(m_cnt);
        sb.push_back(e);
    endtask

    task automatic bits(input string s, input bit rd);
        for (int i = 0; i < s.len(); i++) begin
            step(1'b0, s[i] == "1", rd);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s edge %0d: got %0h expected %0h", name, tag, act, exp);
        end
    endtask

    exp_t cur;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
            cur = sb.pop_front();
            vectors++;
            chk("evt_valid", cur.tag, 32'(evt_valid), 32'(cur.v));
            if (cur.chk_d) chk("evt_data", cur.tag, 32'(evt_data), 32'(cur.d));
            chk("evt_ovf", cur.tag, 32'(evt_ovf), 32'(cur.ovf));
            chk("match", cur.tag, 32'(match), 32'(cur.m));
            chk("match_cnt", cur.tag, 32'(match_cnt), 32'(cur.mc));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int bias;
        int rdy_pct;
        rst       = 1'b1;
        z_in      = 1'b0;
        evt_ready = 1'b0;

        step(1, 0, 0); step(1, 0, 0);
        // Upstream flush: high samples in the settle window never count.
        bits("11", 1); bits("000", 1);
        // Single run of 3.
        bits("01110", 1); bits("00", 1);
        // Two overlapping matches, runs of 1 and 2.
        step(1, 0, 1); bits("11", 1); bits("1011011", 1); bits("00", 1);
        // Full holding register: second run dropped, then drained.
        bits("110111100", 0); step(0, 0, 1); bits("00", 0);
        // Saturating run.
        for (int i = 0; i < 300; i++) step(0, 1, 1);
        bits("00", 1);
        // Drain and load on the same edge.
        bits("10", 0); bits("11", 0); bits("0", 1); bits("00", 1);
        // Reset while an event is held and a run is in progress.
        bits("1011", 0); step(1, 1, 0); bits("111100", 1);
        // Match counter wrap.
        step(1, 0, 1); bits("00", 1); bits("1", 1);
        for (int i = 0; i < 270; i++) bits("011", $urandom_range(0, 1) == 1);
        bits("00", 1);
        // Randomized traffic with occasional resets.
        bias    = 50;
        rdy_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                bias    = $urandom_range(10, 95);
                rdy_pct = $urandom_range(5, 100);
            end
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < bias,
                 $urandom_range(0, 99) < rdy_pct);
        end

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
